// File: rtl/ysyx_23060337_pipe_pkg.sv
// Shared types and constants for the two-entry valid/ready skid buffer.
package ysyx_23060337_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } skid_state_t;

    localparam int PERF_W = 32;

endpackage

// File: rtl/ysyx_23060337_pipe_skid_reg.sv
// Generic enabled flip-flop with synchronous active-high reset to a fixed value.
module ysyx_23060337_Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clk) begin
        if (rst)
            dout <= RESET_VAL;
        else if (wen)
            dout <= din;
    end

endmodule

// File: rtl/ysyx_23060337_pipe_skid.sv
// Two-entry skid buffer between pipeline stages; all outputs come straight from flops.
// Optional perf counters (stall_cnt/block_cnt) are built when YSYX_23060337_PIPE_PERF_EN is defined.
module ysyx_23060337_pipe_skid
    import ysyx_23060337_pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef YSYX_23060337_PIPE_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] block_cnt
`endif
);

    logic [1:0]        state_raw;
    skid_state_t       state_q, state_d;
    logic              out_valid_q, in_ready_q;
    logic [DATA_W-1:0] main_q, main_d, skid_q;
    logic              main_we, skid_we, main_from_skid;
    logic              in_fire, out_fire;

    assign state_q  = skid_state_t'(state_raw);
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d        = state_q;
        main_we        = 1'b0;
        skid_we        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_we = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_we = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_we = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = ONE;
                    main_we        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash wins over everything; held data is left untouched, only state drops.
        if (flush) begin
            state_d = EMPTY;
            main_we = 1'b0;
            skid_we = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    ysyx_23060337_Reg #(.WIDTH(2), .RESET_VAL(EMPTY)) u_state (
        .clk(clk), .rst(rst), .wen(1'b1), .din(state_d), .dout(state_raw)
    );
    ysyx_23060337_Reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_out_valid (
        .clk(clk), .rst(rst), .wen(1'b1), .din(state_d != EMPTY), .dout(out_valid_q)
    );
    ysyx_23060337_Reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_in_ready (
        .clk(clk), .rst(rst), .wen(1'b1), .din(state_d != FULL), .dout(in_ready_q)
    );
    ysyx_23060337_Reg #(.WIDTH(DATA_W), .RESET_VAL(RESET_VAL)) u_main (
        .clk(clk), .rst(rst), .wen(main_we), .din(main_d), .dout(main_q)
    );
    ysyx_23060337_Reg #(.WIDTH(DATA_W), .RESET_VAL('0)) u_skid (
        .clk(clk), .rst(rst), .wen(skid_we), .din(in_data), .dout(skid_q)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign out_data  = main_q;

`ifdef YSYX_23060337_PIPE_PERF_EN
    logic [PERF_W-1:0] stall_q, block_q;
    logic              stall_we, block_we;

    // Saturating counters; flush does not clear them.
    assign stall_we = out_valid_q & ~out_ready & (stall_q != '1);
    assign block_we = in_valid & ~in_ready_q & (block_q != '1);

    ysyx_23060337_Reg #(.WIDTH(PERF_W), .RESET_VAL('0)) u_stall_cnt (
        .clk(clk), .rst(rst), .wen(stall_we), .din(stall_q + PERF_W'(1)), .dout(stall_q)
    );
    ysyx_23060337_Reg #(.WIDTH(PERF_W), .RESET_VAL('0)) u_block_cnt (
        .clk(clk), .rst(rst), .wen(block_we), .din(block_q + PERF_W'(1)), .dout(block_q)
    );

    assign stall_cnt = stall_q;
    assign block_cnt = block_q;
`endif

endmodule

// File: tb/tb_ysyx_23060337_pipe_skid.sv
// Directed self-checking bench for the skid buffer; perf checks run when YSYX_23060337_PIPE_PERF_EN is defined.
module tb_ysyx_23060337_pipe_skid;

    localparam int          DW = 32;
    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
`ifdef YSYX_23060337_PIPE_PERF_EN
    logic [31:0]   stall_cnt, block_cnt;
`endif

    int total = 0;
    int bad   = 0;

    ysyx_23060337_pipe_skid #(.DATA_W(DW), .RESET_VAL(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef YSYX_23060337_PIPE_PERF_EN
        , .stall_cnt(stall_cnt), .block_cnt(block_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (out_data !== RV) begin bad++; $display("FAIL reset_out_data got=%h exp=%h", out_data, RV); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = i;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", i, in_ready); end
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== i) begin
                bad++; $display("FAIL stream_out beat=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, i);
            end
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; step();
        in_data = 32'hB; step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
        in_data = 32'hC; step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hA) begin
            bad++; $display("FAIL bp_hold got=%b/%h exp=1/a", out_valid, out_data);
        end
        out_ready = 1'b1; step();
        total++; if (out_data !== 32'hB) begin bad++; $display("FAIL bp_second got=%h exp=b", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen got=%b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'hC) begin
            bad++; $display("FAIL bp_third got=%b/%h exp=1/c", out_valid, out_data);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; step();
        in_data = 32'h2; step();
        in_data = 32'h3; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_full_ready got=%b exp=1", in_ready); end
        // Flush in ONE while a new beat is actually accepted: it must be dropped.
        in_valid = 1'b1; in_data = 32'h9; step();
        in_data = 32'h3; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_output cyc=%0d got=%b/%h exp=0", k, out_valid, out_data); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h1; step();
        in_data = 32'h2; step();
        in_data = 32'h7; rst = 1'b1; step();
        rst = 1'b0; in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== RV) begin
            bad++; $display("FAIL rstmid_state got=%b/%b/%h exp=0/1/%h", out_valid, in_ready, out_data, RV);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5; step();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h5) begin
            bad++; $display("FAIL rstmid_push got=%b/%h exp=1/5", out_valid, out_data);
        end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_alone got=%b exp=0", out_valid); end
    endtask

`ifdef YSYX_23060337_PIPE_PERF_EN
    task automatic test_perf();
        rst = 1'b1; step(); rst = 1'b0;
        total++;
        if (stall_cnt !== 32'd0 || block_cnt !== 32'd0) begin
            bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cnt, block_cnt);
        end
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11; step();
        in_valid = 1'b0;
        repeat (10) step();
        total++; if (stall_cnt !== 32'd10) begin bad++; $display("FAIL perf_stall got=%0d exp=10", stall_cnt); end
        total++; if (block_cnt !== 32'd0) begin bad++; $display("FAIL perf_block_idle got=%0d exp=0", block_cnt); end
        out_ready = 1'b1; flush = 1'b1; step();
        flush = 1'b0; out_ready = 1'b0;
        total++; if (stall_cnt !== 32'd10) begin bad++; $display("FAIL perf_flush_keep got=%0d exp=10", stall_cnt); end
        in_valid = 1'b1; in_data = 32'h21; step();
        in_data = 32'h22; step();
        repeat (3) step();
        total++; if (block_cnt !== 32'd3) begin bad++; $display("FAIL perf_block got=%0d exp=3", block_cnt); end
        in_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        total++;
        if (stall_cnt !== 32'd0 || block_cnt !== 32'd0) begin
            bad++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", stall_cnt, block_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
`ifdef YSYX_23060337_PIPE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
